// File: rtl/phase_sequencer_pkg.sv
// Shared types and width helpers for the phase sequencer slice.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } seq_state_t;

    function automatic int frame_idx_w(input int num_frames);
        return $clog2(num_frames);
    endfunction

    // One extra bit so out-of-range channel numbers can be seen and rejected.
    function automatic int ch_idx_w(input int num_channels);
        return $clog2(num_channels) + 1;
    endfunction

    localparam int FRAME_IDX_W = frame_idx_w(4);
    localparam int CH_IDX_W    = ch_idx_w(128);

endpackage

// File: rtl/phase_sequencer_if.sv
// Word-write bus into the phase/calibration tables.
interface phase_sequencer_if
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS = 128,
    parameter int CLK_CNT_W    = 8,
    parameter int NUM_FRAMES   = 4
) ();

    localparam int FW = frame_idx_w(NUM_FRAMES);
    localparam int CW = ch_idx_w(NUM_CHANNELS);

    logic                 wr_en;
    logic                 wr_calib;
    logic [FW-1:0]        wr_frame;
    logic [CW-1:0]        wr_channel;
    logic [CLK_CNT_W-1:0] wr_phase;
    logic                 wr_err;

    modport master (
        output wr_en, wr_calib, wr_frame, wr_channel, wr_phase,
        input  wr_err
    );

    modport slave (
        input  wr_en, wr_calib, wr_frame, wr_channel, wr_phase,
        output wr_err
    );

endinterface

// File: rtl/phase_sequencer_seq_ctrl.sv
// Playback FSM: dwell counting, frame stepping, wrap/done pulses.
module phase_sequencer_seq_ctrl
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int DWELL_W    = 16,
    localparam int FW        = frame_idx_w(NUM_FRAMES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic [FW-1:0]      cfg_static_frame,
    input  logic [FW-1:0]      cfg_last_frame,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_oneshot,
    output logic [FW-1:0]      sel,
    output logic [FW-1:0]      frame_idx,
    output logic               seq_wrap,
    output logic               seq_done
);

    seq_state_t         r_state;
    logic [FW-1:0]      r_cur;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [FW-1:0]      r_frame_idx;
    logic               r_wrap;
    logic               r_done;

    logic [FW-1:0]      w_sel;
    logic [DWELL_W-1:0] w_dwell_max;

    assign w_sel       = (r_state == IDLE) ? cfg_static_frame : r_cur;
    assign w_dwell_max = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);

    // start/stop take priority over tick-driven stepping; the tick still shows the pre-command frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_dwell_cnt <= '0;
            r_frame_idx <= '0;
            r_wrap      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            if (tick) begin
                r_frame_idx <= w_sel;
            end
            if (stop) begin
                r_state     <= IDLE;
                r_dwell_cnt <= '0;
            end else if (start) begin
                r_state     <= PLAY;
                r_cur       <= '0;
                r_dwell_cnt <= '0;
            end else if (tick && r_state == PLAY) begin
                if (r_dwell_cnt >= w_dwell_max) begin
                    r_dwell_cnt <= '0;
                    if (r_cur == cfg_last_frame) begin
                        if (cfg_oneshot) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cur  <= '0;
                            r_wrap <= 1'b1;
                        end
                    end else begin
                        r_cur <= r_cur + FW'(1);
                    end
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end

    assign sel       = w_sel;
    assign frame_idx = r_frame_idx;
    assign seq_wrap  = r_wrap;
    assign seq_done  = r_done;

endmodule

// File: rtl/phase_sequencer.sv
// Frame/calibration tables and tick-updated calibrated phase outputs for the transducer array.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS = 128,
    parameter int CLK_CNT_W    = 8,
    parameter int NUM_FRAMES   = 4,
    parameter int DWELL_W      = 16,
    localparam int FW          = frame_idx_w(NUM_FRAMES),
    localparam int CW          = ch_idx_w(NUM_CHANNELS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  tick,
    phase_sequencer_if.slave                      wr_bus,
    input  logic [FW-1:0]                         cfg_static_frame,
    input  logic [FW-1:0]                         cfg_last_frame,
    input  logic [DWELL_W-1:0]                    cfg_dwell,
    input  logic                                  cfg_oneshot,
    input  logic                                  start,
    input  logic                                  stop,
    output logic [NUM_CHANNELS-1:0][CLK_CNT_W-1:0] phases_out,
    output logic [FW-1:0]                         frame_idx,
    output logic                                  seq_wrap,
    output logic                                  seq_done
);

    logic [CLK_CNT_W-1:0] r_frames [NUM_FRAMES][NUM_CHANNELS];
    logic [CLK_CNT_W-1:0] r_calib  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][CLK_CNT_W-1:0] r_phases;
    logic                 r_wr_err;

    logic [FW-1:0]        w_sel;
    logic                 w_ch_ok;
    logic [CW-2:0]        w_ch;

    assign w_ch_ok = wr_bus.wr_channel < CW'(NUM_CHANNELS);
    assign w_ch    = wr_bus.wr_channel[CW-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned f = 0; f < NUM_FRAMES; f++) begin
                for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                    r_frames[f][c] <= '0;
                end
            end
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                r_calib[c] <= '0;
            end
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_bus.wr_en && !w_ch_ok;
            if (wr_bus.wr_en && w_ch_ok) begin
                if (wr_bus.wr_calib) begin
                    r_calib[w_ch] <= wr_bus.wr_phase;
                end else begin
                    r_frames[wr_bus.wr_frame][w_ch] <= wr_bus.wr_phase;
                end
            end
        end
    end

    // Sum wraps mod 2^CLK_CNT_W; a same-cycle table write is not yet visible here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phases <= '0;
        end else if (tick) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                r_phases[c] <= r_frames[w_sel][c] + r_calib[c];
            end
        end
    end

    phase_sequencer_seq_ctrl #(
        .NUM_FRAMES (NUM_FRAMES),
        .DWELL_W    (DWELL_W)
    ) u_seq_ctrl (
        .clk              (clk),
        .rst              (rst),
        .tick             (tick),
        .start            (start),
        .stop             (stop),
        .cfg_static_frame (cfg_static_frame),
        .cfg_last_frame   (cfg_last_frame),
        .cfg_dwell        (cfg_dwell),
        .cfg_oneshot      (cfg_oneshot),
        .sel              (w_sel),
        .frame_idx        (frame_idx),
        .seq_wrap         (seq_wrap),
        .seq_done         (seq_done)
    );

    assign phases_out    = r_phases;
    assign wr_bus.wr_err = r_wr_err;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus queues expectations, a monitor checks each tick/write response.
module tb_phase_sequencer;

    localparam int NCH = 128;
    localparam int W   = 8;
    localparam int NF  = 4;
    localparam int DW  = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    tick = 1'b0;
    logic                    start = 1'b0;
    logic                    stop = 1'b0;
    logic                    cfg_oneshot = 1'b0;
    logic [1:0]              cfg_static_frame = '0;
    logic [1:0]              cfg_last_frame = '0;
    logic [DW-1:0]           cfg_dwell = 16'd1;
    logic [NCH-1:0][W-1:0]   phases_out;
    logic [1:0]              frame_idx;
    logic                    seq_wrap;
    logic                    seq_done;

    phase_sequencer_if #(.NUM_CHANNELS(NCH), .CLK_CNT_W(W), .NUM_FRAMES(NF)) bus ();

    phase_sequencer #(
        .NUM_CHANNELS (NCH),
        .CLK_CNT_W    (W),
        .NUM_FRAMES   (NF),
        .DWELL_W      (DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tick             (tick),
        .wr_bus           (bus),
        .cfg_static_frame (cfg_static_frame),
        .cfg_last_frame   (cfg_last_frame),
        .cfg_dwell        (cfg_dwell),
        .cfg_oneshot      (cfg_oneshot),
        .start            (start),
        .stop             (stop),
        .phases_out       (phases_out),
        .frame_idx        (frame_idx),
        .seq_wrap         (seq_wrap),
        .seq_done         (seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch0;
        int ch5;
        int ch6;
        int fidx;
        int wrap;
        int done;
    } exp_t;

    exp_t q[$];
    int   errq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Response-valid markers: a tick or write accepted at a posedge is visible by the following negedge.
    logic tick_q, wr_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            tick_q <= tick;
            wr_q   <= bus.wr_en;
        end
    end

    exp_t e;
    int   ee;
    always @(negedge clk) begin
        if (!rst) begin
            if (tick_q) begin
                if (q.size() == 0) begin
                    chk("tick_without_expectation", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("ch0",       int'(phases_out[0]), e.ch0);
                    chk("ch5",       int'(phases_out[5]), e.ch5);
                    chk("ch6",       int'(phases_out[6]), e.ch6);
                    chk("frame_idx", int'(frame_idx),     e.fidx);
                    chk("seq_wrap",  int'(seq_wrap),      e.wrap);
                    chk("seq_done",  int'(seq_done),      e.done);
                end
            end
            if (wr_q) begin
                if (errq.size() == 0) begin
                    chk("write_without_expectation", 1, 0);
                end else begin
                    ee = errq.pop_front();
                    chk("wr_err", int'(bus.wr_err), ee);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int c0, input int c5, input int c6, input int f,
                           input int wr, input int dn);
        exp_t x;
        x = '{c0, c5, c6, f, wr, dn};
        q.push_back(x);
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wr(input bit cal, input int fr, input int ch, input int val, input int err);
        bus.wr_en      = 1'b1;
        bus.wr_calib   = cal;
        bus.wr_frame   = 2'(fr);
        bus.wr_channel = 8'(ch);
        bus.wr_phase   = 8'(val);
        errq.push_back(err);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse(input bit s, input bit p);
        start = s;
        stop  = p;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Expected ch0/ch5 per frame after setup: f0 ch5=200 with calib 100 wraps to 44.
    function automatic int c0_of(input int f);
        case (f)
            0: return 10;
            1: return 20;
            2: return 30;
            default: return 0;
        endcase
    endfunction

    function automatic int c5_of(input int f);
        return (f == 0) ? 44 : 100;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    initial begin : stim
        int loop_f[7]    = '{0, 0, 1, 1, 2, 2, 0};
        int once_f[8]    = '{0, 0, 1, 1, 2, 2, 2, 2};
        int fast_f[4]    = '{0, 1, 2, 0};
        exp_t x;

        bus.wr_en = 1'b0; bus.wr_calib = 1'b0; bus.wr_frame = '0;
        bus.wr_channel = '0; bus.wr_phase = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phases_nonzero", int'(|phases_out), 0);
        chk("rst_frame_idx", int'(frame_idx), 0);
        chk("rst_seq_wrap", int'(seq_wrap), 0);
        chk("rst_seq_done", int'(seq_done), 0);
        chk("rst_wr_err", int'(bus.wr_err), 0);
        rst = 1'b0;
        step();

        // Calibration wrap: 200 + 100 -> 44; neighbouring channel untouched.
        cfg_static_frame = 2'd0;
        wr(1'b0, 0, 5, 200, 0);
        wr(1'b1, 0, 5, 100, 0);
        do_tick(0, 44, 0, 0, 0, 0);

        wr(1'b0, 0, 0, 10, 0);
        wr(1'b0, 1, 0, 20, 0);
        wr(1'b0, 2, 0, 30, 0);
        do_tick(10, 44, 0, 0, 0, 0);

        // Looping play, dwell 2, wrap on 6th tick.
        cfg_last_frame = 2'd2;
        cfg_dwell      = 16'd2;
        cfg_oneshot    = 1'b0;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            do_tick(c0_of(loop_f[i]), c5_of(loop_f[i]), 0, loop_f[i], (i == 5) ? 1 : 0, 0);

        // One-shot: done once on 6th tick, then holds frame 2; start restarts at frame 0.
        pulse(1'b0, 1'b1);
        cfg_oneshot = 1'b1;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            do_tick(c0_of(once_f[i]), c5_of(once_f[i]), 0, once_f[i], 0, (i == 5) ? 1 : 0);
        pulse(1'b1, 1'b0);
        do_tick(10, 44, 0, 0, 0, 0);

        // Dwell 0 behaves as 1: advance every tick.
        pulse(1'b0, 1'b1);
        cfg_oneshot = 1'b0;
        cfg_dwell   = 16'd0;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            do_tick(c0_of(fast_f[i]), c5_of(fast_f[i]), 0, fast_f[i], (i == 2) ? 1 : 0, 0);

        // start and stop together: stop wins, static frame shown.
        cfg_static_frame = 2'd1;
        pulse(1'b1, 1'b1);
        do_tick(20, 100, 0, 1, 0, 0);

        // Out-of-range channel: error pulse, no table change (ch 128 aliases ch 0 if mis-decoded).
        wr(1'b1, 0, 128, 55, 1);
        wr(1'b0, 1, 128, 77, 1);
        wr(1'b0, 3, 6, 9, 0);
        do_tick(20, 100, 0, 1, 0, 0);
        cfg_static_frame = 2'd3;
        do_tick(0, 100, 9, 3, 0, 0);

        // Write colliding with tick: old value shown, new value on the next tick.
        cfg_static_frame = 2'd0;
        x = '{10, 44, 0, 0, 0, 0};
        q.push_back(x);
        errq.push_back(0);
        bus.wr_en = 1'b1; bus.wr_calib = 1'b0; bus.wr_frame = 2'd0;
        bus.wr_channel = 8'd0; bus.wr_phase = 8'd99;
        tick = 1'b1;
        step();
        tick = 1'b0;
        bus.wr_en = 1'b0;
        do_tick(99, 44, 0, 0, 0, 0);

        // Reset in the middle of play.
        cfg_dwell = 16'd1;
        pulse(1'b1, 1'b0);
        do_tick(99, 44, 0, 0, 0, 0);
        do_tick(20, 100, 0, 1, 0, 0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midplay_rst_phases_nonzero", int'(|phases_out), 0);
        chk("midplay_rst_frame_idx", int'(frame_idx), 0);
        step();
        rst = 1'b0;
        step();
        wr(1'b0, 2, 0, 7, 0);
        cfg_static_frame = 2'd2;
        do_tick(7, 0, 0, 2, 0, 0);

        for (int i = 0; i < 20 && (q.size() != 0 || errq.size() != 0); i++)
            step();
        chk("pending_tick_expectations", q.size(), 0);
        chk("pending_write_expectations", errq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
